accel_job_dispatcher: RTL and testbench

Host-side initiator for the accelerator's start/done control handshake. Accepts job IDs from the host over a valid/ready port and buffers them in a small FIFO. Issues each job to the accelerator as a one-cycle `acc_start` pulse, waits for the matching `acc_done` (optionally bounded by a watchdog), then returns a completion record over a second valid/ready port. Sits between the host command interface and the accelerator controller; one job is in flight at a time.

---
 rtl/accel_job_dispatcher.sv | 122 ++++++++++++
 tb/tb_accel_job_dispatcher.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_job_dispatcher.sv
// Host-side job dispatcher: buffers job IDs in a FIFO, issues them one at a time
// over an acc_start/acc_done handshake and returns completion records.
// Optional watchdog compiled in with `define ACCEL_DISPATCH_TIMEOUT_EN.
module accel_job_dispatcher #(
    parameter int ID_W    = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ID_W-1:0]              req_id,
    output logic                         acc_start,
    input  logic                         acc_done,
    output logic                         cpl_valid,
    input  logic                         cpl_ready,
    output logic [ID_W-1:0]              cpl_id,
    output logic                         cpl_err,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic              err_q, err_d;
    logic              push, pop, timeout;

    // No pass-through: a push while full is refused even when a pop happens.
    assign req_ready = (count_q != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == ISSUE);
    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign pending   = count_q;

    assign acc_start = (state_q == ISSUE);
    assign cpl_valid = (state_q == REPORT);
    assign cpl_id    = cur_id_q;
    assign cpl_err   = err_q;

`ifdef ACCEL_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] timer_q, timer_d;

    assign timeout = (timer_q == TW'(TIMEOUT-1));

    always_comb begin
        timer_d = timer_q;
        if (state_q == ISSUE)
            timer_d = '0;
        else if (state_q == WAIT && !acc_done && !timeout)
            timer_d = timer_q + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = ISSUE;
            end
            ISSUE: begin
                cur_id_d = mem_q[rd_ptr_q];
                state_d  = WAIT;
            end
            WAIT: begin
                // acc_done beats a coincident timeout
                if (acc_done) begin
                    err_d   = 1'b0;
                    state_d = REPORT;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (cpl_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cur_id_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cur_id_q <= cur_id_d;
            err_q    <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_id;
    end

endmodule

// File: tb/tb_accel_job_dispatcher.sv
// Self-checking bench for accel_job_dispatcher: table-driven single jobs,
// hand-written corner sequences and a randomized run against a queue scoreboard.
module tb_accel_job_dispatcher;

    localparam int ID_W  = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;
    logic            acc_start;
    logic            acc_done;
    logic            cpl_valid;
    logic            cpl_ready;
    logic [ID_W-1:0] cpl_id;
    logic            cpl_err;
    logic [CW-1:0]   pending;

    accel_job_dispatcher #(.ID_W(ID_W), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .acc_start(acc_start), .acc_done(acc_done),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_id(cpl_id), .cpl_err(cpl_err),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accelerator model: done pulse acc_lat cycles after the start pulse.
    logic acc_en = 1'b0;
    int   acc_lat = 3;
    int   rem = 0;
    logic acc_done_m = 1'b0;
    logic acc_done_t = 1'b0;
    assign acc_done = acc_done_m | acc_done_t;

    always @(posedge clk) begin
        logic st;
        st = acc_start;
        #1;
        acc_done_m = 1'b0;
        if (rem > 0) begin
            rem--;
            if (rem == 0) acc_done_m = 1'b1;
        end
        if (st && acc_en) begin
            if (acc_lat == 1) acc_done_m = 1'b1;
            else rem = acc_lat - 1;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One job from an idle, empty dispatcher; cycles are relative to the push cycle.
    task automatic run_job(input logic [ID_W-1:0] id, output int gs, output int gc,
                           output int gi, output int ge, output int ns, output int lo);
        int t0;
        gs = -1; gc = -1; gi = -1; ge = -1; ns = 0; lo = -1;
        step();
        t0 = cyc;
        req_valid = 1'b1;
        req_id    = id;
        cpl_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (acc_start) begin
                ns++;
                if (gs < 0) gs = cyc - t0;
            end
            if (gc >= 0 && cyc - t0 == gc + 1) lo = cpl_valid;
            if (cpl_valid && gc < 0) begin
                gc = cyc - t0; gi = cpl_id; ge = cpl_err;
            end
            step();
            req_valid = 1'b0;
        end
    endtask

    typedef struct {
        logic [ID_W-1:0] id;
        int              lat;
        int              exp_start;
        int              exp_cpl;
    } vec_t;

    int  acc_cnt, start_cnt, cpl_cnt;
    logic [ID_W-1:0] sb_q [$];

    task automatic rand_cycle();
        logic [ID_W-1:0] e;
        @(negedge clk);
        check("pending", pending, acc_cnt - start_cnt);
        check("req_ready", req_ready, (acc_cnt - start_cnt) < DEPTH);
        if (req_valid && req_ready) begin
            sb_q.push_back(req_id);
            acc_cnt++;
        end
        if (acc_start) start_cnt++;
        if (cpl_valid && cpl_ready) begin
            cpl_cnt++;
            if (sb_q.size() == 0) begin
                check("cpl_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("rand_cpl_id", cpl_id, e);
                check("rand_cpl_err", cpl_err, 0);
            end
        end
        check("one_in_flight", (start_cnt - cpl_cnt) <= 1, 1);
    endtask

    initial begin
        vec_t vt [4];
        int gs, gc, gi, ge, ns, lo;
        int nxt, stable, nstart_bp, acc_cyc, st_cyc, ncpl, bad;
        int exp_ids [5];

        vt[0] = '{4'd5,  3, 2, 6};
        vt[1] = '{4'd0,  1, 2, 4};
        vt[2] = '{4'd15, 6, 2, 9};
        vt[3] = '{4'd10, 2, 2, 5};
        exp_ids = '{1, 2, 3, 4, 5};

        reset = 1'b1; req_valid = 1'b0; req_id = '0; cpl_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_acc_start", acc_start, 0);
        check("rst_cpl_valid", cpl_valid, 0);
        check("rst_cpl_id", cpl_id, 0);
        check("rst_cpl_err", cpl_err, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_pending", pending, 0);
        step();
        reset = 1'b0;
        step();

        // Table-driven single jobs
        acc_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc_lat = vt[i].lat;
            run_job(vt[i].id, gs, gc, gi, ge, ns, lo);
            check("job_start_cyc", gs, vt[i].exp_start);
            check("job_nstart", ns, 1);
            check("job_cpl_cyc", gc, vt[i].exp_cpl);
            check("job_cpl_id", gi, vt[i].id);
            check("job_cpl_err", ge, 0);
            check("job_cpl_drop", lo, 0);
        end

        // FIFO full under completion backpressure, then in-order drain
        acc_lat = 3;
        step();
        cpl_ready = 1'b0;
        req_valid = 1'b1; req_id = 4'd1;
        step();
        req_valid = 1'b0;
        bad = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cpl_valid) begin bad = 0; break; end
            step();
        end
        check("full_job1_report", bad, 0);
        nxt = 2; stable = 1; nstart_bp = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            req_valid = 1'b1;
            req_id = ID_W'(nxt);
            @(negedge clk);
            if (!cpl_valid || cpl_id != 4'd1 || cpl_err) stable = 0;
            if (acc_start) nstart_bp++;
            if (req_ready) nxt++;
        end
        check("full_accepted_upto", nxt, 6);
        check("full_pending", pending, 4);
        check("full_req_ready", req_ready, 0);
        check("bp_cpl_stable", stable, 1);
        check("bp_no_start", nstart_bp, 0);
        step();
        req_valid = 1'b0;
        cpl_ready = 1'b1;
        ncpl = 0; acc_cyc = -1; st_cyc = -1;
        for (int k = 0; k < 80 && ncpl < 5; k++) begin
            @(negedge clk);
            if (acc_start && st_cyc < 0) st_cyc = cyc;
            if (cpl_valid && cpl_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                check("drain_id", cpl_id, exp_ids[ncpl]);
                check("drain_err", cpl_err, 0);
                ncpl++;
            end
            step();
        end
        check("drain_count", ncpl, 5);
        check("restart_after_accept", st_cyc - acc_cyc, 2);
        repeat (4) step();

`ifdef ACCEL_DISPATCH_TIMEOUT_EN
        // Watchdog expiry, then a late done in IDLE
        acc_en = 1'b0;
        run_job(4'd3, gs, gc, gi, ge, ns, lo);
        check("tmo_start_cyc", gs, 2);
        check("tmo_cpl_cyc", gc, 11);
        check("tmo_cpl_id", gi, 3);
        check("tmo_cpl_err", ge, 1);
        acc_done_t = 1'b1;
        step();
        acc_done_t = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpl_valid || acc_start) bad = 1;
            step();
        end
        check("tmo_late_done_ignored", bad, 0);
        // Done on the same cycle the watchdog expires
        acc_en = 1'b1; acc_lat = TMO;
        run_job(4'd6, gs, gc, gi, ge, ns, lo);
        check("coinc_cpl_cyc", gc, 11);
        check("coinc_cpl_err", ge, 0);
        acc_lat = 3;
`endif

        // Reset while WAITing with two jobs queued
        acc_en = 1'b0;
        cpl_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            req_valid = 1'b1;
            req_id = ID_W'(7 + k);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("rstw_pending_before", pending, 2);
        check("rstw_in_wait", cpl_valid | acc_start, 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rstw_pending", pending, 0);
        check("rstw_req_ready", req_ready, 1);
        check("rstw_cpl_valid", cpl_valid, 0);
        check("rstw_acc_start", acc_start, 0);
        step();
        reset = 1'b0;
        step();
        acc_done_t = 1'b1;
        step();
        acc_done_t = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cpl_valid || acc_start) bad = 1;
            step();
        end
        check("rstw_no_completion", bad, 0);

        // Randomized traffic against the scoreboard
        acc_en = 1'b1;
        acc_cnt = 0; start_cnt = 0; cpl_cnt = 0;
        for (int k = 0; k < 600; k++) begin
            req_valid = ($urandom_range(0, 9) < 4);
            req_id    = ID_W'($urandom);
            cpl_ready = ($urandom_range(0, 1) == 1);
            acc_lat   = $urandom_range(1, 5);
            rand_cycle();
            step();
        end
        req_valid = 1'b0;
        cpl_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            rand_cycle();
            step();
        end
        check("rand_drained", sb_q.size(), 0);
        check("rand_all_done", cpl_cnt, acc_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
